// File: rtl/pixel_scan_renderer_pkg.sv
// Purpose: shared state encoding, default screen extents and background colour for the pixel scan renderer.
// Latency: none (declarations only).
// Backpressure: none.
package pixel_scan_renderer_pkg;

  // Scan controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_t;

  // Default bus widths.
  localparam int DEF_X_W     = 8;
  localparam int DEF_Y_W     = 8;
  localparam int DEF_COLOR_W = 3;

  // Default screen extents (xMAX / yMAX of the game screen).
  localparam int X_MAX_DEF = 159;
  localparam int Y_MAX_DEF = 119;

  // Background colour (colBG) used while the game is not running.
  localparam int COL_BG = 0;

endpackage

// File: rtl/pixel_scan_renderer_if.sv
// Purpose: query bus (q_x/q_y out, pix_color back) and plot bus (plot strobe + x/y/colour) of the renderer.
// Latency: none (wires only).
// Backpressure: none; the VGA adapter must accept one plot per clock.
// Ports: master = renderer side (drives query and plot), slave = lookup/VGA side (drives pix_color).
interface pixel_scan_renderer_if
  import pixel_scan_renderer_pkg::*;
#(
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int COLOR_W = DEF_COLOR_W
);
  logic [X_W-1:0]     q_x;
  logic [Y_W-1:0]     q_y;
  logic [COLOR_W-1:0] pix_color;
  logic [X_W-1:0]     plot_x;
  logic [Y_W-1:0]     plot_y;
  logic [COLOR_W-1:0] plot_color;
  logic               plot;

  modport master (
    output q_x, q_y, plot_x, plot_y, plot_color, plot,
    input  pix_color
  );

  modport slave (
    input  q_x, q_y, plot_x, plot_y, plot_color, plot,
    output pix_color
  );
endinterface

// File: rtl/pixel_coord_delay.sv
// Purpose: LAT-deep shift register of {valid, x, y} aligning issued coordinates with the colour lookup result.
// Latency: LAT clocks (LAT=0 is a combinational pass-through).
// Backpressure: none; shifts every clock, bubbles travel as valid=0.
// Ports: clk/resetn, vld_i/x_i/y_i entry, vld_o/x_o/y_o tail, any_vld_o = some stored entry is valid.
module pixel_coord_delay
  import pixel_scan_renderer_pkg::*;
#(
  parameter int LAT = 2,
  parameter int X_W = DEF_X_W,
  parameter int Y_W = DEF_Y_W
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           vld_i,
  input  logic [X_W-1:0] x_i,
  input  logic [Y_W-1:0] y_i,
  output logic           vld_o,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           any_vld_o
);

  generate
    if (LAT == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ resetn;
      assign vld_o     = vld_i;
      assign x_o       = x_i;
      assign y_o       = y_i;
      assign any_vld_o = 1'b0;
    end else begin : g_pipe
      logic [LAT-1:0] vld_q;
      logic [X_W-1:0] x_q [LAT];
      logic [Y_W-1:0] y_q [LAT];

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          vld_q <= '0;
          for (int i = 0; i < LAT; i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
          end
        end else begin
          vld_q[0] <= vld_i;
          x_q[0]   <= x_i;
          y_q[0]   <= y_i;
          for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            x_q[i]   <= x_q[i-1];
            y_q[i]   <= y_q[i-1];
          end
        end
      end

      assign vld_o     = vld_q[LAT-1];
      assign x_o       = x_q[LAT-1];
      assign y_o       = y_q[LAT-1];
      assign any_vld_o = |vld_q;
    end
  endgenerate

endmodule

// File: rtl/pixel_scan_renderer.sv
// Purpose: on a frame tick, raster-scan a clamped window one pixel/clk, query colour, emit plot strobes.
// Latency: pixel issued in cycle t plots in cycle t+LOOKUP_LAT+1; first issue one cycle after frame_start.
// Backpressure: enable=0 pauses issue while in-flight pixels keep draining; frame_start while busy -> overrun.
// Ports: clk/resetn; enable, frame_start, render_en, win_x0/x1/y0/y1 control;
//        pix (query + plot bus, master side); busy, frame_done, overrun status.
module pixel_scan_renderer
  import pixel_scan_renderer_pkg::*;
#(
  parameter int X_W        = DEF_X_W,
  parameter int Y_W        = DEF_Y_W,
  parameter int X_MAX      = X_MAX_DEF,
  parameter int Y_MAX      = Y_MAX_DEF,
  parameter int COLOR_W    = DEF_COLOR_W,
  parameter int LOOKUP_LAT = 2,
  parameter int BG_COLOR   = COL_BG
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  frame_start,
  input  logic                  render_en,
  input  logic [X_W-1:0]        win_x0,
  input  logic [X_W-1:0]        win_x1,
  input  logic [Y_W-1:0]        win_y0,
  input  logic [Y_W-1:0]        win_y1,
  pixel_scan_renderer_if.master pix,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam logic [X_W-1:0]     X_LAST = X_W'(X_MAX);
  localparam logic [Y_W-1:0]     Y_LAST = Y_W'(Y_MAX);
  localparam logic [COLOR_W-1:0] BG     = COLOR_W'(BG_COLOR);

  scan_state_t        state_q;
  logic [X_W-1:0]     qx_q, x0_q, x1_q;
  logic [Y_W-1:0]     qy_q, y1_q;
  logic               ren_q, busy_q, done_q, ovr_q;
  logic               plot_q;
  logic [X_W-1:0]     plot_x_q;
  logic [Y_W-1:0]     plot_y_q;
  logic [COLOR_W-1:0] plot_color_q;

  logic [X_W-1:0] x1_clamp;
  logic [Y_W-1:0] y1_clamp;
  logic           win_empty;
  logic           issue;
  logic           tail_vld, pipe_vld;
  logic [X_W-1:0] tail_x;
  logic [Y_W-1:0] tail_y;

  // Clamp the far corner to the screen so the counters can never run past it.
  assign x1_clamp  = (win_x1 > X_LAST) ? X_LAST : win_x1;
  assign y1_clamp  = (win_y1 > Y_LAST) ? Y_LAST : win_y1;
  assign win_empty = (win_x0 > x1_clamp) || (win_y0 > y1_clamp);
  assign issue     = (state_q == ST_SCAN) && enable;

  pixel_coord_delay #(
    .LAT (LOOKUP_LAT),
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_delay (
    .clk       (clk),
    .resetn    (resetn),
    .vld_i     (issue),
    .x_i       (qx_q),
    .y_i       (qy_q),
    .vld_o     (tail_vld),
    .x_o       (tail_x),
    .y_o       (tail_y),
    .any_vld_o (pipe_vld)
  );

  // Scan controller. The frame_done cycle still counts as busy for frame_start,
  // so a tick landing exactly as the frame retires is reported as an overrun.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      qx_q    <= '0;
      qy_q    <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      ren_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            if (done_q) begin
              ovr_q <= 1'b1;
            end else if (win_empty) begin
              done_q <= 1'b1;
            end else begin
              qx_q    <= win_x0;
              qy_q    <= win_y0;
              x0_q    <= win_x0;
              x1_q    <= x1_clamp;
              y1_q    <= y1_clamp;
              ren_q   <= render_en;
              busy_q  <= 1'b1;
              state_q <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (frame_start) ovr_q <= 1'b1;
          if (enable) begin
            // Compare before incrementing so x1/y1 at the type maximum cannot wrap.
            if (qx_q == x1_q) begin
              qx_q <= x0_q;
              if (qy_q == y1_q) state_q <= ST_DRAIN;
              else              qy_q    <= qy_q + 1'b1;
            end else begin
              qx_q <= qx_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (frame_start) ovr_q <= 1'b1;
          // Pipeline empty means the final pixel is on the plot outputs this cycle.
          if (!pipe_vld) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Registered plot stage; coordinates and colour hold between strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      plot_q       <= 1'b0;
      plot_x_q     <= '0;
      plot_y_q     <= '0;
      plot_color_q <= BG;
    end else begin
      plot_q <= tail_vld;
      if (tail_vld) begin
        plot_x_q     <= tail_x;
        plot_y_q     <= tail_y;
        plot_color_q <= ren_q ? pix.pix_color : BG;
      end
    end
  end

  assign pix.q_x        = qx_q;
  assign pix.q_y        = qy_q;
  assign pix.plot       = plot_q;
  assign pix.plot_x     = plot_x_q;
  assign pix.plot_y     = plot_y_q;
  assign pix.plot_color = plot_color_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_pixel_scan_renderer.sv
// Purpose: self-checking bench for pixel_scan_renderer across lookup latencies 0, 2 and 7.
// Latency: n/a.
// Backpressure: n/a.
module tb_pixel_scan_renderer;
  import pixel_scan_renderer_pkg::*;

  localparam int NI = 4;
  localparam int LATS [NI] = '{2, 2, 0, 7};
  localparam int XMX  [NI] = '{3, 159, 3, 3};
  localparam int YMX  [NI] = '{2, 119, 2, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       resetn [NI];
  logic       enable [NI];
  logic       frame_start [NI];
  logic       render_en [NI];
  logic [7:0] win_x0 [NI];
  logic [7:0] win_x1 [NI];
  logic [7:0] win_y0 [NI];
  logic [7:0] win_y1 [NI];
  logic       busy [NI];
  logic       frame_done [NI];
  logic       overrun [NI];
  logic [7:0] q_x [NI];
  logic [7:0] q_y [NI];
  logic [2:0] pix_color [NI];
  logic       m_plot [NI];
  logic [7:0] m_px [NI];
  logic [7:0] m_py [NI];
  logic [2:0] m_pc [NI];

  pixel_scan_renderer_if pif0 ();
  pixel_scan_renderer_if pif1 ();
  pixel_scan_renderer_if pif2 ();
  pixel_scan_renderer_if pif3 ();

  assign pif0.pix_color = pix_color[0];
  assign pif1.pix_color = pix_color[1];
  assign pif2.pix_color = pix_color[2];
  assign pif3.pix_color = pix_color[3];
  assign q_x[0] = pif0.q_x;  assign q_y[0] = pif0.q_y;
  assign q_x[1] = pif1.q_x;  assign q_y[1] = pif1.q_y;
  assign q_x[2] = pif2.q_x;  assign q_y[2] = pif2.q_y;
  assign q_x[3] = pif3.q_x;  assign q_y[3] = pif3.q_y;
  assign m_plot[0] = pif0.plot; assign m_px[0] = pif0.plot_x; assign m_py[0] = pif0.plot_y; assign m_pc[0] = pif0.plot_color;
  assign m_plot[1] = pif1.plot; assign m_px[1] = pif1.plot_x; assign m_py[1] = pif1.plot_y; assign m_pc[1] = pif1.plot_color;
  assign m_plot[2] = pif2.plot; assign m_px[2] = pif2.plot_x; assign m_py[2] = pif2.plot_y; assign m_pc[2] = pif2.plot_color;
  assign m_plot[3] = pif3.plot; assign m_px[3] = pif3.plot_x; assign m_py[3] = pif3.plot_y; assign m_pc[3] = pif3.plot_color;

  pixel_scan_renderer #(.X_MAX(XMX[0]), .Y_MAX(YMX[0]), .LOOKUP_LAT(LATS[0])) dut0 (
    .clk(clk), .resetn(resetn[0]), .enable(enable[0]), .frame_start(frame_start[0]), .render_en(render_en[0]),
    .win_x0(win_x0[0]), .win_x1(win_x1[0]), .win_y0(win_y0[0]), .win_y1(win_y1[0]), .pix(pif0),
    .busy(busy[0]), .frame_done(frame_done[0]), .overrun(overrun[0]));
  pixel_scan_renderer #(.X_MAX(XMX[1]), .Y_MAX(YMX[1]), .LOOKUP_LAT(LATS[1])) dut1 (
    .clk(clk), .resetn(resetn[1]), .enable(enable[1]), .frame_start(frame_start[1]), .render_en(render_en[1]),
    .win_x0(win_x0[1]), .win_x1(win_x1[1]), .win_y0(win_y0[1]), .win_y1(win_y1[1]), .pix(pif1),
    .busy(busy[1]), .frame_done(frame_done[1]), .overrun(overrun[1]));
  pixel_scan_renderer #(.X_MAX(XMX[2]), .Y_MAX(YMX[2]), .LOOKUP_LAT(LATS[2])) dut2 (
    .clk(clk), .resetn(resetn[2]), .enable(enable[2]), .frame_start(frame_start[2]), .render_en(render_en[2]),
    .win_x0(win_x0[2]), .win_x1(win_x1[2]), .win_y0(win_y0[2]), .win_y1(win_y1[2]), .pix(pif2),
    .busy(busy[2]), .frame_done(frame_done[2]), .overrun(overrun[2]));
  pixel_scan_renderer #(.X_MAX(XMX[3]), .Y_MAX(YMX[3]), .LOOKUP_LAT(LATS[3])) dut3 (
    .clk(clk), .resetn(resetn[3]), .enable(enable[3]), .frame_start(frame_start[3]), .render_en(render_en[3]),
    .win_x0(win_x0[3]), .win_x1(win_x1[3]), .win_y0(win_y0[3]), .win_y1(win_y1[3]), .pix(pif3),
    .busy(busy[3]), .frame_done(frame_done[3]), .overrun(overrun[3]));

  // Colour lookup model: colour = (x+y)&7, presented LAT clocks after the query.
  function automatic logic [2:0] col_of(input logic [7:0] x, input logic [7:0] y);
    return 3'(x + y);
  endfunction

  logic [2:0] hist [NI][8];
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      hist[k][0] <= col_of(q_x[k], q_y[k]);
      for (int i = 1; i < 8; i++) hist[k][i] <= hist[k][i-1];
    end
  end

  always_comb begin
    for (int k = 0; k < NI; k++) begin
      if (LATS[k] == 0) pix_color[k] = col_of(q_x[k], q_y[k]);
      else              pix_color[k] = hist[k][(LATS[k] == 0) ? 0 : LATS[k] - 1];
    end
  end

  // Scoreboard and checking.
  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;
  pix_t exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor of the selected instance, sampled on the falling edge.
  int   sel = 0;
  bit   mon_on = 1'b0;
  int   plot_cnt, first_plot, last_plot, busy_cnt, busy_first;
  int   done_cnt, done_cyc, ovr_cnt, ovr_first, ovr_last, gap, max_gap;
  logic [7:0] last_x, last_y;

  task automatic mon_start();
    plot_cnt = 0; first_plot = -1; last_plot = -1; busy_cnt = 0; busy_first = -1;
    done_cnt = 0; done_cyc = -1; ovr_cnt = 0; ovr_first = -1; ovr_last = -1;
    gap = 0; max_gap = 0; last_x = '0; last_y = '0;
    mon_on = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (m_plot[sel]) begin
        pix_t e;
        plot_cnt++;
        if (plot_cnt == 1) first_plot = cyc;
        last_plot = cyc;
        last_x = m_px[sel];
        last_y = m_py[sel];
        if (plot_cnt > 1 && gap > max_gap) max_gap = gap;
        gap = 0;
        check_eq("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("plot_x", 32'(m_px[sel]), 32'(e.x));
          check_eq("plot_y", 32'(m_py[sel]), 32'(e.y));
          check_eq("plot_color", 32'(m_pc[sel]), 32'(e.c));
        end
      end else if (plot_cnt > 0) begin
        gap++;
      end
      if (busy[sel]) begin
        busy_cnt++;
        if (busy_cnt == 1) busy_first = cyc;
      end
      if (frame_done[sel]) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (overrun[sel]) begin
        ovr_cnt++;
        if (ovr_cnt == 1) ovr_first = cyc;
        ovr_last = cyc;
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_fs(input int k);
    frame_start[k] = 1'b1;
    @(negedge clk);
    frame_start[k] = 1'b0;
  endtask

  // Drive one frame request (call at a falling edge) and queue the pixels it should produce.
  task automatic do_frame(input int k, input int x0, input int x1, input int y0, input int y1,
                          input bit ren, output int t0);
    int x1c, y1c;
    win_x0[k] = 8'(x0); win_x1[k] = 8'(x1); win_y0[k] = 8'(y0); win_y1[k] = 8'(y1);
    render_en[k] = ren;
    t0 = cyc;
    x1c = (x1 > XMX[k]) ? XMX[k] : x1;
    y1c = (y1 > YMX[k]) ? YMX[k] : y1;
    for (int y = y0; y <= y1c; y++) begin
      for (int x = x0; x <= x1c; x++) begin
        pix_t p;
        p.x = 8'(x);
        p.y = 8'(y);
        p.c = ren ? 3'((x + y) & 7) : 3'(COL_BG);
        exp_q.push_back(p);
      end
    end
    pulse_fs(k);
    // Scramble the window mid-frame; the frame in progress must not notice.
    win_x0[k] = 8'd1; win_x1[k] = 8'd0; win_y0[k] = 8'd7; win_y1[k] = 8'd2;
    render_en[k] = ~ren;
  endtask

  task automatic frame_checks(input int t0, input int lat, input int n);
    check_eq("plot_cnt", 32'(plot_cnt), 32'(n));
    check_eq("first_plot_cyc", 32'(first_plot), 32'(t0 + lat + 2));
    check_eq("last_plot_cyc", 32'(last_plot), 32'(t0 + lat + 1 + n));
    check_eq("done_cnt", 32'(done_cnt), 32'd1);
    check_eq("done_after_last", 32'(done_cyc > last_plot), 32'd1);
    check_eq("busy_first_cyc", 32'(busy_first), 32'(t0 + 1));
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_test(input int k);
    int t0, tt;
    logic pre;
    sel = k;
    mon_start();
    do_frame(k, 0, 3, 0, 2, 1'b1, t0);
    wait_until(t0 + LATS[k] + 4);
    mon_on = 1'b0;
    #2;
    pre = m_plot[k];
    resetn[k] = 1'b0;
    #1;
    check_eq("pre_rst_plot", 32'(pre), 32'd1);
    check_eq("rst_plot", 32'(m_plot[k]), 32'd0);
    check_eq("rst_busy", 32'(busy[k]), 32'd0);
    check_eq("rst_done", 32'(frame_done[k]), 32'd0);
    #9;
    resetn[k] = 1'b1;
    @(negedge clk);
    exp_q.delete();
    mon_start();
    tt = cyc;
    wait_until(tt + 15);
    check_eq("no_stale_plot", 32'(plot_cnt), 32'd0);
    check_eq("no_stale_busy", 32'(busy_cnt), 32'd0);
    mon_start();
    do_frame(k, 0, 3, 0, 2, 1'b1, t0);
    wait_until(t0 + 40);
    frame_checks(t0, LATS[k], 12);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    for (int k = 0; k < NI; k++) begin
      resetn[k] = 1'b0; enable[k] = 1'b1; frame_start[k] = 1'b0; render_en[k] = 1'b1;
      win_x0[k] = '0; win_x1[k] = '0; win_y0[k] = '0; win_y1[k] = '0;
    end
    #12;
    check_eq("rst_q_x", 32'(q_x[0]), 32'd0);
    check_eq("rst_q_y", 32'(q_y[0]), 32'd0);
    check_eq("rst_plot_x", 32'(m_px[0]), 32'd0);
    check_eq("rst_plot_y", 32'(m_py[0]), 32'd0);
    check_eq("rst_plot_color", 32'(m_pc[0]), 32'(COL_BG));
    check_eq("rst_plot", 32'(m_plot[0]), 32'd0);
    check_eq("rst_busy", 32'(busy[0]), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done[0]), 32'd0);
    check_eq("rst_overrun", 32'(overrun[0]), 32'd0);
    #11;
    for (int k = 0; k < NI; k++) resetn[k] = 1'b1;
    repeat (2) @(negedge clk);

    // Full 4x3 frame, latency 2.
    sel = 0;
    mon_start();
    do_frame(0, 0, 3, 0, 2, 1'b1, t0);
    wait_until(t0 + 30);
    frame_checks(t0, 2, 12);
    check_eq("full_done_cyc", 32'(done_cyc), 32'(t0 + 16));
    check_eq("full_busy_cnt", 32'(busy_cnt), 32'd15);
    check_eq("full_max_gap", 32'(max_gap), 32'd0);

    // Sub-window with rendering disabled: background colour.
    mon_start();
    do_frame(0, 1, 2, 1, 1, 1'b0, t0);
    wait_until(t0 + 20);
    frame_checks(t0, 2, 2);

    // Pause for 5 cycles after the third issue.
    mon_start();
    do_frame(0, 0, 3, 0, 2, 1'b1, t0);
    wait_until(t0 + 4);
    enable[0] = 1'b0;
    wait_until(t0 + 9);
    enable[0] = 1'b1;
    wait_until(t0 + 35);
    check_eq("pause_plot_cnt", 32'(plot_cnt), 32'd12);
    check_eq("pause_first", 32'(first_plot), 32'(t0 + 4));
    check_eq("pause_gap", 32'(max_gap), 32'd5);
    check_eq("pause_last", 32'(last_plot), 32'(t0 + 20));
    check_eq("pause_done_cyc", 32'(done_cyc), 32'(t0 + 21));
    check_eq("pause_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("pause_sb_drained", 32'(exp_q.size()), 32'd0);

    // frame_start mid-scan and on the frame_done cycle.
    mon_start();
    do_frame(0, 0, 3, 0, 2, 1'b1, t0);
    wait_until(t0 + 5);
    pulse_fs(0);
    wait_until(t0 + 16);
    pulse_fs(0);
    wait_until(t0 + 30);
    frame_checks(t0, 2, 12);
    check_eq("ovr_cnt", 32'(ovr_cnt), 32'd2);
    check_eq("ovr_first", 32'(ovr_first), 32'(t0 + 6));
    check_eq("ovr_last", 32'(ovr_last), 32'(t0 + 17));
    check_eq("ovr_busy_cnt", 32'(busy_cnt), 32'd15);

    // Empty window after clamp.
    mon_start();
    do_frame(0, 5, 2, 0, 2, 1'b1, t0);
    wait_until(t0 + 10);
    check_eq("empty_plot_cnt", 32'(plot_cnt), 32'd0);
    check_eq("empty_busy_cnt", 32'(busy_cnt), 32'd0);
    check_eq("empty_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("empty_done_cyc", 32'(done_cyc), 32'(t0 + 1));

    // Window beyond the right/bottom screen edge on the full-size screen.
    sel = 1;
    mon_start();
    do_frame(1, 157, 255, 118, 255, 1'b1, t0);
    wait_until(t0 + 20);
    frame_checks(t0, 2, 6);
    check_eq("clamp_last_x", 32'(last_x), 32'd159);
    check_eq("clamp_last_y", 32'(last_y), 32'd119);

    // Asynchronous reset mid-scan at latencies 2, 0 and 7.
    reset_test(0);
    reset_test(2);
    reset_test(3);

    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
